multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_pkg.sv | 61 ++++++
 rtl/mc_decode.sv | 28 ++
 rtl/multicycle_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the multicycle controller.
//   - mux select encodings for ALU operand A/B and register writeback
//   - controller state encoding (exported on the debug state port)
//   - instruction class produced by mc_decode
//   - RV32I major opcodes recognised by the classifier
package multicycle_ctrl_pkg;

    typedef enum logic [1:0] {
        ASEL0    = 2'd0,
        ASEL_REG = 2'd1,
        ASEL_PC  = 2'd2
    } alu_asel_op_enum;

    typedef enum logic [1:0] {
        BSEL0    = 2'd0,
        BSEL_REG = 2'd1,
        BSEL_IMM = 2'd2
    } alu_bsel_op_enum;

    typedef enum logic [1:0] {
        WB_SEL0    = 2'd0,
        WB_SEL_ALU = 2'd1,
        WB_SEL_MEM = 2'd2,
        WB_SEL_PC  = 2'd3
    } wb_sel_op_enum;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } mc_state_enum;

    // CLS_ILLEGAL is the all-zero value so a cleared class register reads as
    // "nothing valid decoded yet".
    typedef enum logic [3:0] {
        CLS_ILLEGAL = 4'd0,
        CLS_R       = 4'd1,
        CLS_IALU    = 4'd2,
        CLS_LOAD    = 4'd3,
        CLS_STORE   = 4'd4,
        CLS_BRANCH  = 4'd5,
        CLS_JAL     = 4'd6,
        CLS_JALR    = 4'd7,
        CLS_LUI     = 4'd8,
        CLS_AUIPC   = 4'd9
    } inst_class_enum;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode classifier.
// Ports:
//   opcode  in   inst[6:0] of the instruction register
//   cls     out  instruction class; CLS_ILLEGAL for any unrecognised opcode
module mc_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [6:0]     opcode,
    output inst_class_enum cls
);

    always_comb begin
        cls = CLS_ILLEGAL;
        case (opcode)
            OP_R:      cls = CLS_R;
            OP_IALU:   cls = CLS_IALU;
            OP_LOAD:   cls = CLS_LOAD;
            OP_STORE:  cls = CLS_STORE;
            OP_BRANCH: cls = CLS_BRANCH;
            OP_JAL:    cls = CLS_JAL;
            OP_JALR:   cls = CLS_JALR;
            OP_LUI:    cls = CLS_LUI;
            OP_AUIPC:  cls = CLS_AUIPC;
            default:   cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I datapath controller sharing one memory port for
// instruction fetch and data access.
// Ports:
//   clk, rst                       clock, async active-high reset
//   inst                           instruction register contents
//   mem_ready                      memory accepted/completed request
//   br_taken                       branch comparator result (used in EXEC)
//   mem_req/mem_we/mem_addr_sel    memory request controls (addr 0=PC, 1=ALU result)
//   ir_we/mdr_we/alu_res_we        datapath register load enables
//   pc_we/pc_sel                   PC update (0=PC+4, 1=target)
//   asel/bsel/wb_sel               operand and writeback mux selects
//   we_reg                         register-file write enable
//   state                          current state (debug)
//   trap                           sticky illegal-opcode flag
// Optional: MULTICYCLE_CTRL_PERF_EN adds cycle_cnt / instret_cnt (64-bit,
// wrapping) performance counters.
//
// state  | meaning
// FETCH  | read instruction at PC, load IR when memory is ready
// DECODE | classify opcode, latch class
// EXEC   | ALU operation; branches resolve and retire here
// MEM    | data load/store at ALU result; stores retire here
// WB     | register writeback and PC update
// TRAP   | illegal opcode seen; frozen until reset
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     inst,
    input  logic            mem_ready,
    input  logic            br_taken,
    output logic            mem_req,
    output logic            mem_we,
    output logic            mem_addr_sel,
    output logic            ir_we,
    output logic            mdr_we,
    output logic            alu_res_we,
    output logic            pc_we,
    output logic            pc_sel,
    output alu_asel_op_enum asel,
    output alu_bsel_op_enum bsel,
    output wb_sel_op_enum   wb_sel,
    output logic            we_reg,
    output mc_state_enum    state,
    output logic            trap
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [63:0]     cycle_cnt,
    output logic [63:0]     instret_cnt
`endif
);

    mc_state_enum   state_nxt;
    inst_class_enum dec_cls;
    inst_class_enum cls_q;
    logic           unused_inst_hi;

    assign unused_inst_hi = ^inst[31:7];

    mc_decode u_decode (
        .opcode (inst[6:0]),
        .cls    (dec_cls)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
            cls_q <= CLS_ILLEGAL;
        end else begin
            state <= state_nxt;
            if (state == DECODE) begin
                cls_q <= dec_cls;
            end
        end
    end

    // Outputs are gated by rst so an in-flight memory request drops at once
    // rather than waiting for the state register to settle.
    always_comb begin
        state_nxt    = state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        mdr_we       = 1'b0;
        alu_res_we   = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 1'b0;
        asel         = ASEL0;
        bsel         = BSEL0;
        wb_sel       = WB_SEL0;
        we_reg       = 1'b0;
        trap         = 1'b0;
        if (!rst) begin
            case (state)
                FETCH: begin
                    mem_req = 1'b1;
                    ir_we   = mem_ready;
                    if (mem_ready) begin
                        state_nxt = DECODE;
                    end
                end
                DECODE: begin
                    state_nxt = (dec_cls == CLS_ILLEGAL) ? TRAP : EXEC;
                end
                EXEC: begin
                    alu_res_we = 1'b1;
                    state_nxt  = WB;
                    case (cls_q)
                        CLS_R: begin
                            asel = ASEL_REG;
                            bsel = BSEL_REG;
                        end
                        CLS_IALU, CLS_JALR: begin
                            asel = ASEL_REG;
                            bsel = BSEL_IMM;
                        end
                        CLS_LOAD, CLS_STORE: begin
                            asel      = ASEL_REG;
                            bsel      = BSEL_IMM;
                            state_nxt = MEM;
                        end
                        CLS_LUI: begin
                            bsel = BSEL_IMM;
                        end
                        CLS_AUIPC, CLS_JAL: begin
                            asel = ASEL_PC;
                            bsel = BSEL_IMM;
                        end
                        CLS_BRANCH: begin
                            asel       = ASEL_PC;
                            bsel       = BSEL_IMM;
                            alu_res_we = 1'b0;
                            pc_we      = 1'b1;
                            pc_sel     = br_taken;
                            state_nxt  = FETCH;
                        end
                        default: begin
                            alu_res_we = 1'b0;
                            state_nxt  = TRAP;
                        end
                    endcase
                end
                MEM: begin
                    // Request fields depend only on state and class, so they
                    // stay constant for the whole wait.
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = (cls_q == CLS_STORE);
                    if (cls_q == CLS_LOAD) begin
                        mdr_we = mem_ready;
                        if (mem_ready) begin
                            state_nxt = WB;
                        end
                    end else begin
                        pc_we = mem_ready;
                        if (mem_ready) begin
                            state_nxt = FETCH;
                        end
                    end
                end
                WB: begin
                    we_reg    = 1'b1;
                    pc_we     = 1'b1;
                    state_nxt = FETCH;
                    case (cls_q)
                        CLS_LOAD: wb_sel = WB_SEL_MEM;
                        CLS_JAL, CLS_JALR: begin
                            wb_sel = WB_SEL_PC;
                            pc_sel = 1'b1;
                        end
                        default:  wb_sel = WB_SEL_ALU;
                    endcase
                end
                TRAP: begin
                    trap = 1'b1;
                end
                default: begin
                    state_nxt = FETCH;
                end
            endcase
        end
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic retire;

    assign retire = (state_nxt == FETCH) &&
                    ((state == EXEC) || (state == MEM) || (state == WB));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt   <= 64'd0;
            instret_cnt <= 64'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 64'd1;
            if (retire) begin
                instret_cnt <= instret_cnt + 64'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: each instruction is expanded into the list
// of per-cycle expected states/controls, then driven and compared cycle by
// cycle. Optional counters are checked when MULTICYCLE_CTRL_PERF_EN is set.
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic [31:0]     inst;
    logic            mem_ready;
    logic            br_taken;
    logic            mem_req, mem_we, mem_addr_sel;
    logic            ir_we, mdr_we, alu_res_we;
    logic            pc_we, pc_sel;
    alu_asel_op_enum asel;
    alu_bsel_op_enum bsel;
    wb_sel_op_enum   wb_sel;
    logic            we_reg;
    mc_state_enum    state;
    logic            trap;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [63:0]     cycle_cnt;
    logic [63:0]     instret_cnt;
`endif

    multicycle_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .inst         (inst),
        .mem_ready    (mem_ready),
        .br_taken     (br_taken),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_we        (ir_we),
        .mdr_we       (mdr_we),
        .alu_res_we   (alu_res_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .asel         (asel),
        .bsel         (bsel),
        .wb_sel       (wb_sel),
        .we_reg       (we_reg),
        .state        (state),
        .trap         (trap)
`ifdef MULTICYCLE_CTRL_PERF_EN
        ,
        .cycle_cnt    (cycle_cnt),
        .instret_cnt  (instret_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef enum int {K_R, K_IALU, K_LOAD, K_STORE, K_BRANCH, K_JAL, K_JALR,
                      K_LUI, K_AUIPC, K_ILL} kind_t;

    typedef struct {
        mc_state_enum st;
        logic         rdy;
        logic         br;
        logic [15:0]  ctl;
    } cyc_t;

    cyc_t q[$];

    logic [15:0] dut_ctl;
    assign dut_ctl = {mem_req, mem_we, mem_addr_sel, ir_we, mdr_we, alu_res_we,
                      pc_we, pc_sel, we_reg, trap, asel, bsel, wb_sel};

    function automatic logic [15:0] mk(bit req, bit we, bit as, bit ir, bit mdr,
                                       bit alu, bit pcw, bit pcs, bit wr, bit tr,
                                       logic [1:0] a, logic [1:0] b, logic [1:0] w);
        return {req, we, as, ir, mdr, alu, pcw, pcs, wr, tr, a, b, w};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] opc(kind_t k);
        case (k)
            K_R:      return 7'h33;
            K_IALU:   return 7'h13;
            K_LOAD:   return 7'h03;
            K_STORE:  return 7'h23;
            K_BRANCH: return 7'h63;
            K_JAL:    return 7'h6f;
            K_JALR:   return 7'h67;
            K_LUI:    return 7'h37;
            K_AUIPC:  return 7'h17;
            default:  return 7'h00;
        endcase
    endfunction

    function automatic logic [6:0] rand_illegal();
        logic [6:0] o;
        for (int i = 0; i < 200; i++) begin
            o = 7'($urandom);
            if (o != 7'h33 && o != 7'h13 && o != 7'h03 && o != 7'h23 && o != 7'h63 &&
                o != 7'h6f && o != 7'h67 && o != 7'h37 && o != 7'h17)
                return o;
        end
        return 7'h00;
    endfunction

    task automatic push(mc_state_enum st, logic rdy, logic br, logic [15:0] ctl);
        cyc_t c;
        c.st = st; c.rdy = rdy; c.br = br; c.ctl = ctl;
        q.push_back(c);
    endtask

    // Expected cycle list for one instruction, built from the instruction's
    // lifecycle: fetch (with waits), decode, execute, optional memory phase
    // (with waits), optional writeback.
    task automatic plan(kind_t k, int fw, int mw, logic br);
        logic [1:0] a, b, w;
        bit ld, st, jmp;
        ld  = (k == K_LOAD);
        st  = (k == K_STORE);
        jmp = (k == K_JAL) || (k == K_JALR);
        for (int i = 0; i < fw; i++)
            push(FETCH, 1'b0, rb(), mk(1,0,0,0,0,0,0,0,0,0, ASEL0, BSEL0, WB_SEL0));
        push(FETCH, 1'b1, rb(), mk(1,0,0,1,0,0,0,0,0,0, ASEL0, BSEL0, WB_SEL0));
        push(DECODE, rb(), rb(), mk(0,0,0,0,0,0,0,0,0,0, ASEL0, BSEL0, WB_SEL0));
        if (k == K_ILL) return;
        case (k)
            K_R:                          begin a = ASEL_REG; b = BSEL_REG; end
            K_IALU, K_LOAD, K_STORE, K_JALR: begin a = ASEL_REG; b = BSEL_IMM; end
            K_LUI:                        begin a = ASEL0;    b = BSEL_IMM; end
            default:                      begin a = ASEL_PC;  b = BSEL_IMM; end
        endcase
        if (k == K_BRANCH) begin
            push(EXEC, rb(), br, mk(0,0,0,0,0,0,1,br,0,0, a, b, WB_SEL0));
            return;
        end
        push(EXEC, rb(), rb(), mk(0,0,0,0,0,1,0,0,0,0, a, b, WB_SEL0));
        if (ld || st) begin
            for (int i = 0; i < mw; i++)
                push(MEM, 1'b0, rb(), mk(1,st,1,0,0,0,0,0,0,0, ASEL0, BSEL0, WB_SEL0));
            push(MEM, 1'b1, rb(), mk(1,st,1,0,ld,0,st,0,0,0, ASEL0, BSEL0, WB_SEL0));
        end
        if (st) return;
        w = ld ? WB_SEL_MEM : (jmp ? WB_SEL_PC : WB_SEL_ALU);
        push(WB, rb(), rb(), mk(0,0,0,0,0,0,1,jmp,1,0, ASEL0, BSEL0, w));
    endtask

    // Called at posedge+1; drives inputs, samples at posedge+3.
    task automatic run_cycles(int n);
        cyc_t c;
        for (int i = 0; i < n && q.size() > 0; i++) begin
            c = q.pop_front();
            mem_ready = c.rdy;
            br_taken  = c.br;
            #2;
            check_eq("state", 64'(state), 64'(c.st));
            check_eq("ctl", 64'(dut_ctl), 64'(c.ctl));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_instr(kind_t k, int fw, int mw, logic br);
        inst = {25'($urandom), (k == K_ILL) ? rand_illegal() : opc(k)};
        plan(k, fw, mw, br);
        run_cycles(q.size());
    endtask

    task automatic release_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_in_reset(string tag);
        check_eq({tag, "_state"}, 64'(state), 64'(FETCH));
        check_eq({tag, "_ctl"}, 64'(dut_ctl), 64'd0);
        check_eq({tag, "_trap"}, 64'(trap), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        inst      = 32'h003100b3;
        mem_ready = 1'b1;
        br_taken  = 1'b0;
        #3;
        check_in_reset("reset");
        release_reset();

`ifdef MULTICYCLE_CTRL_PERF_EN
        check_eq("cycle_cnt_rst", cycle_cnt, 64'd0);
        check_eq("instret_rst", instret_cnt, 64'd0);
        for (int i = 0; i < 3; i++) do_instr(K_R, 0, 0, 1'b0);
        check_eq("cycle_cnt", cycle_cnt, 64'd12);
        check_eq("instret_cnt", instret_cnt, 64'd3);
`endif

        // add x1,x2,x3 with no waits
        inst = 32'h003100b3;
        plan(K_R, 0, 0, 1'b0);
        for (int i = 0; i < q.size(); i++) q[i].rdy = 1'b1;
        run_cycles(q.size());

        // lw with 2 fetch waits and 3 memory waits (10 cycles)
        do_instr(K_LOAD, 2, 3, 1'b0);
        do_instr(K_BRANCH, 0, 0, 1'b1);
        do_instr(K_BRANCH, 0, 0, 1'b0);
        do_instr(K_JAL, 0, 0, 1'b0);
        do_instr(K_LUI, 0, 0, 1'b0);
        do_instr(K_STORE, 1, 2, 1'b0);
        do_instr(K_JALR, 0, 0, 1'b0);
        do_instr(K_AUIPC, 0, 0, 1'b0);
        do_instr(K_IALU, 3, 0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            do_instr(kind_t'($urandom_range(0, 8)), $urandom_range(0, 3),
                     $urandom_range(0, 3), rb());
        end

        // reset during a load's memory wait
        inst = {25'($urandom), opc(K_LOAD)};
        plan(K_LOAD, 0, 6, 1'b0);
        run_cycles(5);
        mem_ready = 1'b0;
        rst = 1'b1;
        #1;
        check_in_reset("rst_mem");
        @(posedge clk);
        #1;
        check_in_reset("rst_hold");
        rst = 1'b0;
        q.delete();
        do_instr(K_R, 0, 0, 1'b0);

        // opcode 0 traps; TRAP holds with no enables
        inst = 32'h00000000;
        plan(K_ILL, 1, 0, 1'b0);
        for (int i = 0; i < 6; i++)
            push(TRAP, rb(), rb(), mk(0,0,0,0,0,0,0,0,0,1, ASEL0, BSEL0, WB_SEL0));
        run_cycles(q.size());
        rst = 1'b1;
        #1;
        check_in_reset("rst_trap");
        release_reset();

        // random illegal opcode, then recovery
        do_instr(K_ILL, 0, 0, 1'b0);
        for (int i = 0; i < 3; i++)
            push(TRAP, rb(), rb(), mk(0,0,0,0,0,0,0,0,0,1, ASEL0, BSEL0, WB_SEL0));
        run_cycles(q.size());
        rst = 1'b1;
        #1;
        check_in_reset("rst_trap2");
        release_reset();
        do_instr(K_LOAD, 0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
